// File: rtl/fa_tlb_pkg.sv
// Shared types and match/merge helpers for the fully associative TLB.
// Used by the lookup, fill-dedup and flush paths so all three agree on page-size masking.
package tlb_pkg;

  localparam int TLB_ASID_W = 16;
  localparam int TLB_VPN_W  = 27;
  localparam int TLB_PPN_W  = 44;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  typedef enum logic [1:0] {
    LVL_4K = 2'd0,
    LVL_2M = 2'd1,
    LVL_1G = 2'd2
  } tlb_level_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tlb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [TLB_ASID_W-1:0] asid;
    logic [TLB_VPN_W-1:0]  vpn;
    logic [TLB_PPN_W-1:0]  ppn;
    logic [7:0]            perm;
    logic [1:0]            level;
  } tlb_entry_t;

  // Superpages ignore the low VPN levels; an undefined level code is treated as 4K.
  function automatic logic vpn_eq(input logic [TLB_VPN_W-1:0] a,
                                  input logic [TLB_VPN_W-1:0] b,
                                  input logic [1:0]           lvl);
    logic eq;
    case (lvl)
      LVL_1G:  eq = (a[TLB_VPN_W-1:18] == b[TLB_VPN_W-1:18]);
      LVL_2M:  eq = (a[TLB_VPN_W-1:9] == b[TLB_VPN_W-1:9]);
      default: eq = (a == b);
    endcase
    return eq;
  endfunction

  function automatic logic entry_hit(input tlb_entry_t            e,
                                     input logic [TLB_VPN_W-1:0]  vpn,
                                     input logic [TLB_ASID_W-1:0] asid);
    return e.valid && ((e.asid == asid) || e.perm[PTE_G]) && vpn_eq(e.vpn, vpn, e.level);
  endfunction

  function automatic logic [TLB_PPN_W-1:0] merge_ppn(input tlb_entry_t           e,
                                                     input logic [TLB_VPN_W-1:0] vpn);
    logic [TLB_PPN_W-1:0] p;
    case (e.level)
      LVL_1G:  p = {e.ppn[TLB_PPN_W-1:18], vpn[17:0]};
      LVL_2M:  p = {e.ppn[TLB_PPN_W-1:9], vpn[8:0]};
      default: p = e.ppn;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fa_tlb_if.sv
// Lookup, fill and flush ports of the TLB; slave is the TLB side, master the requester side.
interface fa_tlb_if import tlb_pkg::*; #(
  parameter int ASID_W = TLB_ASID_W,
  parameter int VPN_W  = TLB_VPN_W,
  parameter int PPN_W  = TLB_PPN_W
);
  logic              lookup_valid_i;
  logic [VPN_W-1:0]  lookup_vpn_i;
  logic [ASID_W-1:0] lookup_asid_i;
  logic              lookup_valid_o;
  logic              lookup_hit_o;
  logic [PPN_W-1:0]  lookup_ppn_o;
  logic [7:0]        lookup_perm_o;

  logic              fill_valid_i;
  logic              fill_ready_o;
  logic [VPN_W-1:0]  fill_vpn_i;
  logic [ASID_W-1:0] fill_asid_i;
  logic [PPN_W-1:0]  fill_ppn_i;
  logic [7:0]        fill_perm_i;
  logic [1:0]        fill_level_i;

  logic              flush_valid_i;
  logic              flush_ready_o;
  logic              flush_vpn_valid_i;
  logic              flush_asid_valid_i;
  logic [VPN_W-1:0]  flush_vpn_i;
  logic [ASID_W-1:0] flush_asid_i;
  logic              busy_o;

  modport slave (
    input  lookup_valid_i, lookup_vpn_i, lookup_asid_i,
    output lookup_valid_o, lookup_hit_o, lookup_ppn_o, lookup_perm_o,
    input  fill_valid_i, fill_vpn_i, fill_asid_i, fill_ppn_i, fill_perm_i, fill_level_i,
    output fill_ready_o,
    input  flush_valid_i, flush_vpn_valid_i, flush_asid_valid_i, flush_vpn_i, flush_asid_i,
    output flush_ready_o, busy_o
  );

  modport master (
    output lookup_valid_i, lookup_vpn_i, lookup_asid_i,
    input  lookup_valid_o, lookup_hit_o, lookup_ppn_o, lookup_perm_o,
    output fill_valid_i, fill_vpn_i, fill_asid_i, fill_ppn_i, fill_perm_i, fill_level_i,
    input  fill_ready_o,
    output flush_valid_i, flush_vpn_valid_i, flush_asid_valid_i, flush_vpn_i, flush_asid_i,
    input  flush_ready_o, busy_o
  );
endinterface

// File: rtl/fa_tlb_plru.sv
// Tree pseudo-LRU: each node bit points toward the less recently used half (1 = upper half).
module fa_tlb_plru #(
  parameter int  ENTRIES = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             access_hit_i,
  input  logic [IDX_W-1:0] access_idx_i,
  output logic [IDX_W-1:0] replacement_idx_o
);

  logic [ENTRIES-2:0] tree_q;
  logic [ENTRIES-2:0] tree_d;

  // Heap-ordered nodes: root 0, children of n at 2n+1 and 2n+2.
  always_comb begin
    int node;
    node   = 0;
    tree_d = tree_q;
    for (int l = 0; l < IDX_W; l++) begin
      tree_d[node[IDX_W-1:0]] = ~access_idx_i[IDX_W-1-l];
      node = 2 * node + 1 + int'(access_idx_i[IDX_W-1-l]);
    end
  end

  always_comb begin
    int node;
    node              = 0;
    replacement_idx_o = '0;
    for (int l = 0; l < IDX_W; l++) begin
      replacement_idx_o[IDX_W-1-l] = tree_q[node[IDX_W-1:0]];
      node = 2 * node + 1 + int'(tree_q[node[IDX_W-1:0]]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tree_q <= '0;
    end else if (access_hit_i) begin
      tree_q <= tree_d;
    end
  end

endmodule

// File: rtl/fa_tlb.sv
// Fully associative TLB: combinational match with a registered lookup result, walker fill
// port with in-place dedup / free-slot / PLRU victim selection, and a sequential sfence walk.
module fa_tlb import tlb_pkg::*; #(
  parameter int ENTRIES = 8,
  parameter int ASID_W  = TLB_ASID_W,
  parameter int VPN_W   = TLB_VPN_W,
  parameter int PPN_W   = TLB_PPN_W
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  fa_tlb_if.slave tlb
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_entry_t        ent_q [ENTRIES];
  tlb_state_e        state_q;
  logic [IDX_W-1:0]  flush_idx_q;
  logic              flush_vpn_v_q;
  logic              flush_asid_v_q;
  logic [VPN_W-1:0]  flush_vpn_q;
  logic [ASID_W-1:0] flush_asid_q;

  logic [ENTRIES-1:0] lk_match_p0, dup_match, inv_match;
  logic               lk_hit_p0;
  logic [IDX_W-1:0]   lk_idx_p0, fill_idx, repl_idx, plru_idx;
  logic [PPN_W-1:0]   lk_ppn_p0;
  logic [7:0]         lk_perm_p0;
  logic               fill_fire, flush_fire, flush_kill, plru_hit;
  tlb_entry_t         fill_ent, flush_ent;

  logic              lk_vld_p1, lk_hit_p1;
  logic [PPN_W-1:0]  lk_ppn_p1;
  logic [7:0]        lk_perm_p1;

  function automatic logic [IDX_W-1:0] first_set(input logic [ENTRIES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign tlb.flush_ready_o = (state_q == ST_IDLE);
  assign tlb.fill_ready_o  = (state_q == ST_IDLE) && !tlb.flush_valid_i;
  assign tlb.busy_o        = (state_q == ST_FLUSH);
  assign flush_fire        = tlb.flush_valid_i && tlb.flush_ready_o;
  assign fill_fire         = tlb.fill_valid_i && tlb.fill_ready_o;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match_p0[i] = entry_hit(ent_q[i], tlb.lookup_vpn_i, tlb.lookup_asid_i);
      dup_match[i]   = ent_q[i].valid && (ent_q[i].asid == tlb.fill_asid_i) &&
                       (ent_q[i].level == tlb.fill_level_i) &&
                       vpn_eq(ent_q[i].vpn, tlb.fill_vpn_i, ent_q[i].level);
      inv_match[i]   = !ent_q[i].valid;
    end
    lk_idx_p0  = first_set(lk_match_p0);
    lk_hit_p0  = tlb.lookup_valid_i && (|lk_match_p0) && (state_q == ST_IDLE);
    lk_ppn_p0  = merge_ppn(ent_q[lk_idx_p0], tlb.lookup_vpn_i);
    lk_perm_p0 = ent_q[lk_idx_p0].perm;

    if (|dup_match)      fill_idx = first_set(dup_match);
    else if (|inv_match) fill_idx = first_set(inv_match);
    else                 fill_idx = repl_idx;

    fill_ent = '{valid: 1'b1, asid: tlb.fill_asid_i, vpn: tlb.fill_vpn_i,
                 ppn: tlb.fill_ppn_i, perm: tlb.fill_perm_i, level: tlb.fill_level_i};

    // Fill wins the PLRU port over a simultaneous lookup hit.
    plru_hit = fill_fire || lk_hit_p0;
    plru_idx = fill_fire ? fill_idx : lk_idx_p0;

    // G entries survive ASID-qualified flushes.
    flush_ent  = ent_q[flush_idx_q];
    flush_kill = (!flush_vpn_v_q || vpn_eq(flush_ent.vpn, flush_vpn_q, flush_ent.level)) &&
                 (!flush_asid_v_q || ((flush_ent.asid == flush_asid_q) && !flush_ent.perm[PTE_G]));
  end

  fa_tlb_plru #(.ENTRIES(ENTRIES)) u_plru (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .access_hit_i      (plru_hit),
    .access_idx_i      (plru_idx),
    .replacement_idx_o (repl_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      flush_idx_q    <= '0;
      flush_vpn_v_q  <= 1'b0;
      flush_asid_v_q <= 1'b0;
      flush_vpn_q    <= '0;
      flush_asid_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_fire) begin
            state_q        <= ST_FLUSH;
            flush_idx_q    <= '0;
            flush_vpn_v_q  <= tlb.flush_vpn_valid_i;
            flush_asid_v_q <= tlb.flush_asid_valid_i;
            flush_vpn_q    <= tlb.flush_vpn_i;
            flush_asid_q   <= tlb.flush_asid_i;
          end
          if (fill_fire) ent_q[fill_idx] <= fill_ent;
        end
        ST_FLUSH: begin
          if (flush_kill) ent_q[flush_idx_q].valid <= 1'b0;
          flush_idx_q <= flush_idx_q + 1'b1;
          if (flush_idx_q == IDX_W'(ENTRIES - 1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // p0 -> p1: match result registered; misses and flush-time lookups return zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lk_vld_p1  <= 1'b0;
      lk_hit_p1  <= 1'b0;
      lk_ppn_p1  <= '0;
      lk_perm_p1 <= '0;
    end else begin
      lk_vld_p1  <= tlb.lookup_valid_i;
      lk_hit_p1  <= lk_hit_p0;
      lk_ppn_p1  <= lk_hit_p0 ? lk_ppn_p0 : '0;
      lk_perm_p1 <= lk_hit_p0 ? lk_perm_p0 : '0;
    end
  end

  assign tlb.lookup_valid_o = lk_vld_p1;
  assign tlb.lookup_hit_o   = lk_hit_p1;
  assign tlb.lookup_ppn_o   = lk_ppn_p1;
  assign tlb.lookup_perm_o  = lk_perm_p1;

endmodule
